// File: rtl/cvm300_pkg.sv
// Shared definitions for the CMV300 pixel-capture slice.
//   cvm300_state_e : capture FSM state encoding (also used by the debug port)
//   PIX_PER_WORD   : pixels packed into one 32-bit FIFO word
//   COLS_DEFAULT / ROWS_DEFAULT : default sensor geometry
package cvm300_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DONE      = 3'd4
  } cvm300_state_e;

  localparam int PIX_PER_WORD = 4;
  localparam int COLS_DEFAULT = 648;
  localparam int ROWS_DEFAULT = 488;

endpackage

// File: rtl/cvm300_pixel_capture_if.sv
// Bus bundle of the pixel-capture block: host control, sensor pixel bus,
// readout-FIFO write port and status.
//   master : the capture block (drives request, FIFO write and status)
//   slave  : the environment (host, sensor, FIFO)
// Handshake: Fifo_Wr_En is the valid strobe for Fifo_Din and lasts one cycle
// per word. Fifo_Full acts as an inverted ready sampled on that same cycle;
// there is no back-pressure, so a word offered while Fifo_Full=1 is dropped
// (Fifo_Wr_En held low) rather than retried. The sensor bus has no ready at
// all: a pixel is taken on every cycle with Line_valid & Data_valid high.
interface cvm300_pixel_capture_if;
  logic        Capture_Arm;
  logic        Clear_Status;
  logic        Line_valid;
  logic        Data_valid;
  logic [7:0]  Pix_D;
  logic        Fifo_Full;
  logic        Frame_Req;
  logic        Fifo_Wr_En;
  logic [31:0] Fifo_Din;
  logic        Busy;
  logic        Frame_Done;
  logic [9:0]  Line_Count;
  logic        Overflow;
  logic        Line_Err;
  logic        Timeout_Err;

  modport master (
    input  Capture_Arm, Clear_Status, Line_valid, Data_valid, Pix_D, Fifo_Full,
    output Frame_Req, Fifo_Wr_En, Fifo_Din, Busy, Frame_Done, Line_Count,
           Overflow, Line_Err, Timeout_Err
  );

  modport slave (
    output Capture_Arm, Clear_Status, Line_valid, Data_valid, Pix_D, Fifo_Full,
    input  Frame_Req, Fifo_Wr_En, Fifo_Din, Busy, Frame_Done, Line_Count,
           Overflow, Line_Err, Timeout_Err
  );
endinterface

// File: rtl/cvm300_pixel_packer.sv
// Packs 8-bit pixels little-endian into 32-bit words.
//   clk, rst_n  : pixel clock, async active-low reset
//   pix_valid   : take pix this cycle
//   pix         : pixel byte
//   flush       : line ended; emit any partial word zero-padded
//   fifo_full   : FIFO full flag, checked on the write cycle
//   word        : packed word, valid while wr is high
//   wr          : FIFO write strobe (one cycle after the 4th pixel / flush)
//   drop        : a word was due but discarded because the FIFO was full
module cvm300_pixel_packer
  import cvm300_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [7:0]  pix,
  input  logic        flush,
  input  logic        fifo_full,
  output logic [31:0] word,
  output logic        wr,
  output logic        drop
);

  logic [23:0] pack;    // lower three lanes; the fourth byte goes straight to word_q
  logic [1:0]  lane;
  logic [31:0] word_q;
  logic        pend;    // word_q holds a word to be offered this cycle

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack   <= '0;
      lane   <= '0;
      word_q <= '0;
      pend   <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (pix_valid) begin
        if (lane == 2'(PIX_PER_WORD - 1)) begin
          word_q <= {pix, pack};
          pend   <= 1'b1;
          pack   <= '0;
          lane   <= '0;
        end else begin
          case (lane)
            2'd0:    pack[7:0]   <= pix;
            2'd1:    pack[15:8]  <= pix;
            default: pack[23:16] <= pix;
          endcase
          lane <= lane + 2'd1;
        end
      end else if (flush) begin
        // Unused lanes are already zero because pack is cleared per word.
        if (lane != 2'd0) begin
          word_q <= {8'h00, pack};
          pend   <= 1'b1;
        end
        pack <= '0;
        lane <= '0;
      end
    end
  end

  assign word = word_q;
  assign wr   = pend & ~fifo_full;
  assign drop = pend & fifo_full;

endmodule

// File: rtl/cvm300_pixel_capture.sv
// CMV300 frame capture: requests one frame on Capture_Arm, samples the 8-bit
// pixel bus while Line_valid & Data_valid, packs 4 pixels per FIFO word and
// reports frame completion and sticky error status.
//   Pixel_Clk, Reset_N : sensor output clock, async active-low reset
//   bus                : control / sensor / FIFO / status bundle (master side)
//   state_dbg          : current FSM state, for observation only
module cvm300_pixel_capture
  import cvm300_pkg::*;
#(
  parameter int COLS           = COLS_DEFAULT,
  parameter int ROWS           = ROWS_DEFAULT,
  parameter int REQ_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   Pixel_Clk,
  input  logic                   Reset_N,
  cvm300_pixel_capture_if.master bus,
  output cvm300_state_e          state_dbg
);

  localparam int RQ_W = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  cvm300_state_e   state;
  logic [RQ_W-1:0] req_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [9:0]      pix_cnt;
  logic [9:0]      line_cnt;
  logic            lv_q;
  logic            frame_req, busy, frame_done;
  logic            overflow, line_err, timeout_err;

  logic sample, pix_keep, pix_extra, line_end, drop;

  // A pixel is taken in WAIT_DATA (the first one) and in CAPTURE.
  assign sample    = ((state == ST_WAIT_DATA) || (state == ST_CAPTURE)) &&
                     bus.Line_valid && bus.Data_valid;
  assign pix_keep  = sample && (pix_cnt < 10'(COLS));
  assign pix_extra = sample && !(pix_cnt < 10'(COLS));
  assign line_end  = (state == ST_CAPTURE) && lv_q && !bus.Line_valid;

  cvm300_pixel_packer u_packer (
    .clk       (Pixel_Clk),
    .rst_n     (Reset_N),
    .pix_valid (pix_keep),
    .pix       (bus.Pix_D),
    .flush     (line_end),
    .fifo_full (bus.Fifo_Full),
    .word      (bus.Fifo_Din),
    .wr        (bus.Fifo_Wr_En),
    .drop      (drop)
  );

  always_ff @(posedge Pixel_Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state       <= ST_IDLE;
      req_cnt     <= '0;
      to_cnt      <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      lv_q        <= 1'b0;
      frame_req   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      line_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      lv_q       <= bus.Line_valid;
      frame_done <= 1'b0;

      // Clear first so that an error event later in this block wins.
      if (bus.Clear_Status) begin
        overflow    <= 1'b0;
        line_err    <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (drop)      overflow <= 1'b1;
      if (pix_extra) line_err <= 1'b1;
      // Saturating so an absurdly long line cannot wrap back to COLS.
      if (sample && (pix_cnt != 10'h3FF)) pix_cnt <= pix_cnt + 10'd1;

      case (state)
        ST_IDLE: begin
          if (bus.Capture_Arm) begin
            state     <= ST_REQ;
            busy      <= 1'b1;
            frame_req <= 1'b1;
            req_cnt   <= '0;
            line_cnt  <= '0;
            pix_cnt   <= '0;
          end
        end
        ST_REQ: begin
          if (req_cnt == RQ_W'(REQ_CYCLES - 1)) begin
            frame_req <= 1'b0;
            to_cnt    <= '0;
            state     <= ST_WAIT_DATA;
          end else begin
            req_cnt <= req_cnt + 1'b1;
          end
        end
        ST_WAIT_DATA: begin
          if (bus.Line_valid && bus.Data_valid) begin
            state <= ST_CAPTURE;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (line_end) begin
            line_cnt <= line_cnt + 10'd1;
            pix_cnt  <= '0;
            if (pix_cnt != 10'(COLS)) line_err <= 1'b1;
            if (line_cnt == 10'(ROWS - 1)) begin
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Frame_Req   = frame_req;
  assign bus.Busy        = busy;
  assign bus.Frame_Done  = frame_done;
  assign bus.Line_Count  = line_cnt;
  assign bus.Overflow    = overflow;
  assign bus.Line_Err    = line_err;
  assign bus.Timeout_Err = timeout_err;
  assign state_dbg       = state;

endmodule

// File: tb/tb_cvm300_pixel_capture.sv
// Self-checking bench for cvm300_pixel_capture with a small 8x2 geometry.
module tb_cvm300_pixel_capture;
  import cvm300_pkg::*;

  localparam int COLS           = 8;
  localparam int ROWS           = 2;
  localparam int REQ_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 16;

  // ---------------- clock / reset ----------------
  logic Pixel_Clk = 1'b0;
  logic Reset_N   = 1'b0;
  always #5 Pixel_Clk = ~Pixel_Clk;

  cvm300_pixel_capture_if bus();
  cvm300_state_e state_dbg;

  cvm300_pixel_capture #(
    .COLS(COLS), .ROWS(ROWS), .REQ_CYCLES(REQ_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .Pixel_Clk (Pixel_Clk),
    .Reset_N   (Reset_N),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  int req_hi   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected FIFO words for one line of n consecutive pixels starting at base:
  // only the first COLS pixels are kept, grouped by four, lowest pixel in the
  // lowest byte, a trailing partial group padded with zero bytes.
  function automatic void model_line(input int n, input logic [7:0] base);
    int kept;
    logic [31:0] w;
    logic [7:0]  p;
    kept = (n < COLS) ? n : COLS;
    for (int g = 0; g < (kept + 3) / 4; g++) begin
      w = '0;
      for (int b = 0; b < 4; b++) begin
        if (g * 4 + b < kept) begin
          p = base + 8'(g * 4 + b);
          w = w | (32'(p) << (8 * b));
        end
      end
      exp_q.push_back(w);
    end
  endfunction

  // Compare process: every FIFO write must match the next expected word.
  always @(negedge Pixel_Clk) begin
    if (Reset_N) begin
      if (bus.Frame_Req)  req_hi++;
      if (bus.Frame_Done) done_cnt++;
      if (bus.Fifo_Wr_En) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL stray_write: got 0x%08h expected no write", bus.Fifo_Din);
        end else begin
          check("fifo_word", bus.Fifo_Din, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Pixel_Clk);
    #1;
  endtask

  task automatic arm_pulse();
    bus.Capture_Arm = 1'b1;
    tick();
    bus.Capture_Arm = 1'b0;
  endtask

  task automatic clear_pulse();
    bus.Clear_Status = 1'b1;
    tick();
    bus.Clear_Status = 1'b0;
  endtask

  // full_after: index of the 4th pixel whose word meets Fifo_Full (-1: none).
  task automatic drive_line(input int n, input logic [7:0] base, input int full_after);
    for (int i = 0; i < n; i++) begin
      bus.Line_valid = 1'b1;
      bus.Data_valid = 1'b1;
      bus.Pix_D      = base + 8'(i);
      bus.Fifo_Full  = (full_after >= 0) && (i == full_after + 1);
      tick();
    end
    bus.Line_valid = 1'b0;
    bus.Data_valid = 1'b0;
    bus.Pix_D      = 8'h00;
    bus.Fifo_Full  = (full_after >= 0) && (full_after == n - 1);
    tick();
    bus.Fifo_Full = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (bus.Busy && n < bound) begin
      tick();
      n++;
    end
    if (bus.Busy) begin
      n_vec++;
      n_fail++;
      $display("FAIL idle_wait: got busy after %0d cycles expected idle", bound);
    end
    tick();
    tick();
  endtask

  task automatic frame_checks(input int req0, input int done0, input logic ovf,
                              input logic lerr);
    check("frame_req_cycles", 32'(req_hi - req0), 32'(REQ_CYCLES));
    check("frame_done_pulses", 32'(done_cnt - done0), 32'd1);
    check("line_count", 32'(bus.Line_Count), 32'(ROWS));
    check("overflow", 32'(bus.Overflow), 32'(ovf));
    check("line_err", 32'(bus.Line_Err), 32'(lerr));
    check("timeout_err", 32'(bus.Timeout_Err), 32'd0);
    check("busy_end", 32'(bus.Busy), 32'd0);
    check("words_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clean_frame(input int req0, input int done0);
    model_line(8, 8'h00);
    model_line(8, 8'h08);
    arm_pulse();
    repeat (6) tick();
    drive_line(8, 8'h00, -1);
    drive_line(8, 8'h08, -1);
    wait_idle(20);
    frame_checks(req0, done0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int req0, done0, n;
    bus.Capture_Arm  = 1'b0;
    bus.Clear_Status = 1'b0;
    bus.Line_valid   = 1'b0;
    bus.Data_valid   = 1'b0;
    bus.Pix_D        = 8'h00;
    bus.Fifo_Full    = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_frame_req", 32'(bus.Frame_Req), 32'd0);
    check("rst_line_count", 32'(bus.Line_Count), 32'd0);
    check("rst_wr_en", 32'(bus.Fifo_Wr_En), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    Reset_N = 1'b1;
    repeat (2) tick();

    // 1: clean 8x2 frame, pixels 0x00..0x0F; literal words pin the model
    req0 = req_hi; done0 = done_cnt;
    model_line(8, 8'h00);
    check("model_w0", exp_q[0], 32'h03020100);
    check("model_w1", exp_q[1], 32'h07060504);
    model_line(8, 8'h08);
    check("model_w3", exp_q[3], 32'h0F0E0D0C);
    arm_pulse();
    repeat (6) tick();
    drive_line(8, 8'h00, -1);
    check("line_count_mid", 32'(bus.Line_Count), 32'd1);
    drive_line(8, 8'h08, -1);
    wait_idle(20);
    frame_checks(req0, done0, 1'b0, 1'b0);

    // 2: FIFO full while the second word is offered -> dropped, Overflow
    req0 = req_hi; done0 = done_cnt;
    model_line(8, 8'h00);
    model_line(8, 8'h08);
    exp_q.delete(1);
    check("model_drop_w1", exp_q[1], 32'h0B0A0908);
    arm_pulse();
    repeat (6) tick();
    drive_line(8, 8'h00, 7);
    drive_line(8, 8'h08, -1);
    wait_idle(20);
    frame_checks(req0, done0, 1'b1, 1'b0);
    clear_pulse();
    check("overflow_cleared", 32'(bus.Overflow), 32'd0);

    // 3: short line of 6 pixels -> zero-padded word, Line_Err
    req0 = req_hi; done0 = done_cnt;
    model_line(6, 8'hA0);
    check("model_short_w0", exp_q[0], 32'hA3A2A1A0);
    check("model_short_w1", exp_q[1], 32'h0000A5A4);
    model_line(8, 8'hB0);
    arm_pulse();
    repeat (6) tick();
    drive_line(6, 8'hA0, -1);
    check("short_line_count", 32'(bus.Line_Count), 32'd1);
    check("short_line_err", 32'(bus.Line_Err), 32'd1);
    drive_line(8, 8'hB0, -1);
    wait_idle(20);
    frame_checks(req0, done0, 1'b0, 1'b1);
    clear_pulse();
    check("line_err_cleared", 32'(bus.Line_Err), 32'd0);

    // 3b: over-long line of 10 pixels -> extras discarded, Line_Err
    req0 = req_hi; done0 = done_cnt;
    model_line(10, 8'hC0);
    check("model_long_words", 32'(exp_q.size()), 32'd2);
    model_line(8, 8'hD0);
    arm_pulse();
    repeat (6) tick();
    drive_line(10, 8'hC0, -1);
    drive_line(8, 8'hD0, -1);
    wait_idle(20);
    frame_checks(req0, done0, 1'b0, 1'b1);
    clear_pulse();

    // 4: no sensor activity -> timeout after REQ + 16 wait cycles
    req0 = req_hi; done0 = done_cnt;
    arm_pulse();
    n = 0;
    while (bus.Busy && n < 100) begin
      tick();
      n++;
    end
    check("timeout_busy_cycles", 32'(n), 32'(REQ_CYCLES + TIMEOUT_CYCLES));
    check("timeout_err", 32'(bus.Timeout_Err), 32'd1);
    check("timeout_no_done", 32'(done_cnt - done0), 32'd0);
    check("timeout_req_cycles", 32'(req_hi - req0), 32'(REQ_CYCLES));
    check("timeout_state", 32'(state_dbg), 32'(ST_IDLE));

    // 5: async reset mid-line after two pixels; Timeout_Err still set here
    arm_pulse();
    repeat (6) tick();
    bus.Line_valid = 1'b1;
    bus.Data_valid = 1'b1;
    bus.Pix_D = 8'h55;
    tick();
    bus.Pix_D = 8'h56;
    tick();
    check("busy_before_reset", 32'(bus.Busy), 32'd1);
    #2;
    Reset_N = 1'b0;
    #1;
    check("arst_busy", 32'(bus.Busy), 32'd0);
    check("arst_wr_en", 32'(bus.Fifo_Wr_En), 32'd0);
    check("arst_din", bus.Fifo_Din, 32'd0);
    check("arst_timeout_err", 32'(bus.Timeout_Err), 32'd0);
    check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    bus.Line_valid = 1'b0;
    bus.Data_valid = 1'b0;
    bus.Pix_D = 8'h00;
    repeat (2) tick();
    Reset_N = 1'b1;
    repeat (3) tick();
    req0 = req_hi; done0 = done_cnt;
    clean_frame(req0, done0);

    // 6: Capture_Arm while busy is ignored
    req0 = req_hi; done0 = done_cnt;
    model_line(8, 8'h00);
    model_line(8, 8'h08);
    arm_pulse();
    tick();
    arm_pulse();
    repeat (4) tick();
    drive_line(8, 8'h00, -1);
    arm_pulse();
    drive_line(8, 8'h08, -1);
    wait_idle(20);
    frame_checks(req0, done0, 1'b0, 1'b0);
    repeat (4) tick();
    check("rearm_stays_idle", 32'(bus.Busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
